inv_cipher_core: RTL and testbench

//  Iterative AES inverse cipher. Decrypts one 128-bit block over NR clock cycles by reusing a

---
 rtl/inv_cipher_core.sv | 208 ++++++++++++++++++++
 tb/tb_inv_cipher_core.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_cipher_core.sv
// inv_cipher_core -- iterative AES inverse cipher.
//
// Decrypts one 128-bit block over NR cycles by reusing a single inverse-round
// datapath. The NR+1 round keys live in an internal key file that can only be
// written while the core is idle. Both data ports use valid/ready handshakes.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   key_wr_en/idx/data  round-key write (idx 0 = cipher key, NR = last round key)
//   key_wr_ready        key file writable (IDLE only)
//   in_valid/in_ready/in_data     ciphertext input handshake
//   out_valid/out_ready/out_data  plaintext output handshake
//   abort               synchronous cancel of the block in flight
//   busy                block in flight (ROUND or DONE)
//
// Build option
//   INV_CIPHER_ZEROIZE_EN  clears the state register after the output
//                          handshake and on abort, masks out_data while not
//                          valid, and wipes the key file on abort.
//
// state | meaning
// IDLE  | waiting for a ciphertext block; key file writable
// ROUND | one inverse round per cycle, rnd counts NR-1 down to 0
// DONE  | plaintext presented, waiting for out_ready
module inv_cipher_core #(
  parameter  int NR     = 10,
  localparam int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_wr_en,
  input  logic [KIDX_W-1:0] key_wr_idx,
  input  logic [127:0]      key_wr_data,
  output logic              key_wr_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  input  logic              abort,
  output logic              busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $fatal(1, "inv_cipher_core: NR must be 10, 12 or 14 (got %0d)", NR);
  end

  localparam logic [KIDX_W-1:0] NR_IDX    = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] RND_START = KIDX_W'(NR - 1);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [KIDX_W-1:0] rnd_q, rnd_d;
  logic [127:0]      blk_q, blk_d;
  logic [127:0]      key_q [0:NR];
  logic [127:0]      key_d [0:NR];
  logic [KIDX_W-1:0] rk_sel;
  logic [127:0]      rk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse affine transform (rotl 1, 3, 6 plus 0x05) followed by inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] t;
    t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Byte i of a block is bits [127-8i -: 8]; byte 4c+r is row r of column c.
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic         last,
                                             input logic [127:0] key);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    // Row r of column c comes from column (c - r) mod 4 before substitution.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[4*c+r] = inv_sbox(b[4*((c-r+4)%4)+r]) ^ key[127-8*(4*c+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) b[4*c+r] = t[4*c+r];
      end else begin
        b[4*c+0] = gf_mul(8'h0e, t[4*c]) ^ gf_mul(8'h0b, t[4*c+1]) ^
                   gf_mul(8'h0d, t[4*c+2]) ^ gf_mul(8'h09, t[4*c+3]);
        b[4*c+1] = gf_mul(8'h09, t[4*c]) ^ gf_mul(8'h0e, t[4*c+1]) ^
                   gf_mul(8'h0b, t[4*c+2]) ^ gf_mul(8'h0d, t[4*c+3]);
        b[4*c+2] = gf_mul(8'h0d, t[4*c]) ^ gf_mul(8'h09, t[4*c+1]) ^
                   gf_mul(8'h0e, t[4*c+2]) ^ gf_mul(8'h0b, t[4*c+3]);
        b[4*c+3] = gf_mul(8'h0b, t[4*c]) ^ gf_mul(8'h0d, t[4*c+1]) ^
                   gf_mul(8'h09, t[4*c+2]) ^ gf_mul(8'h0e, t[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i];
    return res;
  endfunction

  assign key_wr_ready = (fsm_q == S_IDLE);
  assign rk_sel       = (fsm_q == S_ROUND) ? rnd_q : NR_IDX;
  assign rk           = key_q[rk_sel];

  always_comb begin
    fsm_d     = fsm_q;
    rnd_d     = rnd_q;
    blk_d     = blk_q;
    key_d     = key_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    // Out-of-range indices match no entry and are dropped. A write landing
    // on the accept edge does not affect that block: it already used key_q.
    if (key_wr_en && key_wr_ready) begin
      for (int i = 0; i <= NR; i++) begin
        if (key_wr_idx == KIDX_W'(i)) key_d[i] = key_wr_data;
      end
    end

    unique case (fsm_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !abort) begin
          blk_d = in_data ^ rk;
          rnd_d = RND_START;
          fsm_d = S_ROUND;
        end
      end
      S_ROUND: begin
        busy  = 1'b1;
        blk_d = inv_round(blk_q, rnd_q == '0, rk);
        if (rnd_q == '0) fsm_d = S_DONE;
        else             rnd_d = rnd_q - KIDX_W'(1);
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = S_IDLE;
`ifdef INV_CIPHER_ZEROIZE_EN
          blk_d = '0;
`endif
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    if (abort) begin
      if (fsm_q != S_IDLE) begin
        fsm_d = S_IDLE;
        rnd_d = '0;
        blk_d = blk_q;
      end
`ifdef INV_CIPHER_ZEROIZE_EN
      blk_d = '0;
      for (int i = 0; i <= NR; i++) key_d[i] = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
      rnd_q <= '0;
      blk_q <= '0;
      for (int i = 0; i <= NR; i++) key_q[i] <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      blk_q <= blk_d;
      for (int i = 0; i <= NR; i++) key_q[i] <= key_d[i];
    end
  end

`ifdef INV_CIPHER_ZEROIZE_EN
  assign out_data = out_valid ? blk_q : '0;
`else
  assign out_data = blk_q;
`endif

endmodule

// File: tb/tb_inv_cipher_core.sv
// Bench for inv_cipher_core: instance 0 is AES-128 (NR=10), instance 1 is
// AES-256 (NR=14). Expected plaintexts come from FIPS-197 constants and from
// a byte-matrix reference model of the inverse cipher over a shadow key file.
module tb_inv_cipher_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         key_wr_en    [2];
  logic [3:0]   key_wr_idx   [2];
  logic [127:0] key_wr_data  [2];
  logic         key_wr_ready [2];
  logic         in_valid     [2];
  logic         in_ready     [2];
  logic [127:0] in_data      [2];
  logic         out_valid    [2];
  logic         out_ready    [2];
  logic [127:0] out_data     [2];
  logic         abort        [2];
  logic         busy         [2];

  inv_cipher_core #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_wr_en(key_wr_en[0]), .key_wr_idx(key_wr_idx[0]), .key_wr_data(key_wr_data[0]),
    .key_wr_ready(key_wr_ready[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .abort(abort[0]), .busy(busy[0])
  );

  inv_cipher_core #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n),
    .key_wr_en(key_wr_en[1]), .key_wr_idx(key_wr_idx[1]), .key_wr_data(key_wr_data[1]),
    .key_wr_ready(key_wr_ready[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .abort(abort[1]), .busy(busy[1])
  );

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk_tab [15];
  logic [127:0] mk [2][15];

  typedef struct {
    int           d;
    logic [127:0] ct;
    logic [127:0] pt;
    string        nm;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nr_of(input int d);
    return (d == 0) ? 10 : 14;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 8'h00) begin
      if (y[0]) p ^= x;
      x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] imc_coef(input int r, input int k);
    case ((k - r + 4) % 4)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // State as st[row][col]; column c of a 128-bit word is bytes 4c..4c+3.
  function automatic logic [127:0] model_dec(input int d, input logic [127:0] ct);
    logic [7:0]   st  [4][4];
    logic [7:0]   tmp [4][4];
    logic [127:0] k;
    logic [127:0] res;
    int nr = nr_of(d);
    k = mk[d][nr];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = ct[127-8*(4*c+r) -: 8] ^ k[127-8*(4*c+r) -: 8];
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      k = mk[d][rnd];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = st[r][(c - r + 4) % 4];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          st[r][c] = isbox[tmp[r][c]] ^ k[127-8*(4*c+r) -: 8];
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            tmp[r][c] = 8'h00;
            for (int j = 0; j < 4; j++) tmp[r][c] ^= gmul(imc_coef(r, j), st[j][c]);
          end
        st = tmp;
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = st[r][c];
    return res;
  endfunction

  task automatic clear_model(input int d);
    for (int i = 0; i < 15; i++) mk[d][i] = '0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic write_key(input int d, input int idx, input logic [127:0] data);
    @(negedge clk);
    key_wr_en[d]   = 1'b1;
    key_wr_idx[d]  = 4'(idx);
    key_wr_data[d] = data;
    @(negedge clk);
    key_wr_en[d] = 1'b0;
    if (idx <= nr_of(d)) mk[d][idx] = data;
  endtask

  task automatic load_tab(input int d);
    for (int r = 0; r <= nr_of(d); r++) write_key(d, r, rk_tab[r]);
  endtask

  // Called at the negedge right after the accept edge plus lat0 cycles.
  task automatic finish_block(input int d, input logic [127:0] exp, input string nm,
                              input int lat0, input int hold);
    int lat = lat0;
    while (!out_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk_i({nm, "_latency"}, lat, nr_of(d));
    chk({nm, "_data"}, out_data[d], exp);
    chk_b({nm, "_busy_done"}, busy[d], 1'b1);
    chk_b({nm, "_in_ready_done"}, in_ready[d], 1'b0);
    for (int h = 0; h < hold; h++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = rand128();
      @(negedge clk);
      chk_b({nm, "_hold_valid"}, out_valid[d], 1'b1);
      chk({nm, "_hold_data"}, out_data[d], exp);
      chk_b({nm, "_hold_in_ready"}, in_ready[d], 1'b0);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
    chk_b({nm, "_out_valid_after"}, out_valid[d], 1'b0);
    chk_b({nm, "_busy_after"}, busy[d], 1'b0);
    chk_b({nm, "_in_ready_after"}, in_ready[d], 1'b1);
  endtask

  task automatic accept(input int d, input logic [127:0] ct, input string nm,
                        input logic side_wr, input logic [127:0] side_data);
    @(negedge clk);
    chk_b({nm, "_in_ready_idle"}, in_ready[d], 1'b1);
    in_valid[d] = 1'b1;
    in_data[d]  = ct;
    if (side_wr) begin
      key_wr_en[d]   = 1'b1;
      key_wr_idx[d]  = 4'(nr_of(d));
      key_wr_data[d] = side_data;
    end
    @(negedge clk);
    in_valid[d]  = 1'b0;
    in_data[d]   = rand128();
    key_wr_en[d] = 1'b0;
    if (side_wr) mk[d][nr_of(d)] = side_data;
  endtask

  task automatic run_block(input int d, input logic [127:0] ct, input logic [127:0] exp,
                           input string nm);
    accept(d, ct, nm, 1'b0, '0);
    finish_block(d, exp, nm, 0, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] ct;
    logic [127:0] saved;
    int hi;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      key_wr_en[d] = 1'b0; key_wr_idx[d] = '0; key_wr_data[d] = '0;
      in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0; abort[d] = 1'b0;
      clear_model(d);
    end
    build_tables();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk_b("rst_in_ready", in_ready[d], 1'b1);
      chk_b("rst_key_wr_ready", key_wr_ready[d], 1'b1);
      chk_b("rst_out_valid", out_valid[d], 1'b0);
      chk_b("rst_busy", busy[d], 1'b0);
      chk("rst_out_data", out_data[d], '0);
    end

    expand_key(K128, 4, 10);
    load_tab(0);
    expand_key(K256, 8, 14);
    load_tab(1);

    vecs[0].d = 0; vecs[0].ct = C1_CT; vecs[0].pt = PT; vecs[0].nm = "fips_c1";
    vecs[1].d = 1; vecs[1].ct = C3_CT; vecs[1].pt = PT; vecs[1].nm = "fips_c3";
    for (int i = 2; i < 8; i++) begin
      vecs[i].d  = i % 2;
      vecs[i].ct = rand128();
      vecs[i].pt = model_dec(i % 2, vecs[i].ct);
      vecs[i].nm = $sformatf("vec%0d", i);
    end
    for (int i = 0; i < 8; i++) run_block(vecs[i].d, vecs[i].ct, vecs[i].pt, vecs[i].nm);

    // Backpressure: 5 cycles in DONE with in_valid held, then release.
    accept(0, C1_CT, "bp", 1'b0, '0);
    finish_block(0, PT, "bp", 0, 5);

    // Writes while busy are dropped.
    accept(0, C1_CT, "busy_wr", 1'b0, '0);
    chk_b("busy_key_wr_ready", key_wr_ready[0], 1'b0);
    key_wr_en[0] = 1'b1; key_wr_idx[0] = 4'd10; key_wr_data[0] = rand128();
    @(negedge clk);
    key_wr_idx[0] = 4'd0;
    @(negedge clk);
    key_wr_idx[0] = 4'd5;
    @(negedge clk);
    key_wr_en[0] = 1'b0;
    finish_block(0, PT, "busy_wr", 3, 0);
    run_block(0, C1_CT, PT, "busy_wr_rerun");

    // Out-of-range index in IDLE is dropped.
    write_key(0, 11, rand128());
    write_key(0, 15, rand128());
    run_block(0, C1_CT, PT, "idx_oob");

    // Write of key[NR] on the accept edge: this block uses the old key.
    saved = mk[0][10];
    accept(0, C1_CT, "same_cyc", 1'b1, rand128());
    finish_block(0, PT, "same_cyc", 0, 0);
    ct = rand128();
    run_block(0, ct, model_dec(0, ct), "new_key_nr");
    write_key(0, 10, saved);

    // Abort in IDLE beats in_valid.
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = C1_CT; abort[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0; abort[0] = 1'b0;
    chk_b("abort_idle_busy", busy[0], 1'b0);
    chk_b("abort_idle_in_ready", in_ready[0], 1'b1);
`ifdef INV_CIPHER_ZEROIZE_EN
    clear_model(0);
    expand_key(K128, 4, 10);
    load_tab(0);
`endif

    // Abort with rnd=4: five edges after the accept edge.
    accept(0, C1_CT, "abort_rnd", 1'b0, '0);
    repeat (5) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk_b("abort_rnd_busy", busy[0], 1'b0);
    chk_b("abort_rnd_out_valid", out_valid[0], 1'b0);
    chk_b("abort_rnd_in_ready", in_ready[0], 1'b1);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid[0]) hi++;
    end
    chk_i("abort_rnd_no_output", hi, 0);
`ifdef INV_CIPHER_ZEROIZE_EN
    clear_model(0);
    run_block(0, C1_CT, model_dec(0, C1_CT), "post_abort");
    expand_key(K128, 4, 10);
    load_tab(0);
`else
    run_block(0, C1_CT, PT, "post_abort");
`endif

    // Random round-key files on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r <= nr_of(d); r++) write_key(d, r, rand128());
      for (int i = 0; i < 3; i++) begin
        ct = rand128();
        run_block(d, ct, model_dec(d, ct), $sformatf("rk_rand_d%0d_%0d", d, i));
      end
    end

    // Asynchronous reset in the middle of ROUND.
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b1; in_data[d] = rand128();
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_b("mid_rst_in_ready", in_ready[d], 1'b1);
      chk_b("mid_rst_key_wr_ready", key_wr_ready[d], 1'b1);
      chk_b("mid_rst_out_valid", out_valid[d], 1'b0);
      chk_b("mid_rst_busy", busy[d], 1'b0);
      chk("mid_rst_out_data", out_data[d], '0);
      clear_model(d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_b("post_rst_in_ready", in_ready[0], 1'b1);
    for (int d = 0; d < 2; d++) begin
      ct = rand128();
      run_block(d, ct, model_dec(d, ct), $sformatf("zero_keys_d%0d", d));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
